// File: rtl/vid_colour_bbox_tracker.sv
// ---------------------------------------------------------------------------
// vid_colour_bbox_tracker
// Sits behind the clocked-video output on the pixel clock. It passes the video
// through with one cycle of latency and, for every frame, finds the bounding
// box and pixel count of pixels inside an RGB threshold window. It hands one
// result per frame to the host over a valid/ready handshake.
//
// Ports
//   clk, reset_n                    pixel clock, synchronous active-low reset
//   vid_data/datavalid/h_sync/v_sync  incoming RGB888 video and timing
//   thr_r_min/thr_g_max/thr_b_max    match: R>=r_min, G<=g_max, B<=b_max
//   out_data/datavalid/h_sync/v_sync  video to the VGA DAC, 1 clk behind input
//   res_valid/res_ready              result handshake
//   res_found/res_x_*/res_y_*/res_count  per-frame result
//   res_overrun                      sticky: an unconsumed result was replaced
//
// Build option: define BBOX_OVERLAY_EN to draw the border of the last
// reported box in white on the outgoing video.
// ---------------------------------------------------------------------------
module vid_colour_bbox_tracker #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned MIN_PIX  = 64,
    parameter int unsigned CW       = 20
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [23:0]                 vid_data,
    input  logic                        vid_datavalid,
    input  logic                        vid_h_sync,
    input  logic                        vid_v_sync,
    input  logic [7:0]                  thr_r_min,
    input  logic [7:0]                  thr_g_max,
    input  logic [7:0]                  thr_b_max,
    output logic [23:0]                 out_data,
    output logic                        out_datavalid,
    output logic                        out_h_sync,
    output logic                        out_v_sync,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        res_found,
    output logic [$clog2(H_ACTIVE)-1:0] res_x_min,
    output logic [$clog2(H_ACTIVE)-1:0] res_x_max,
    output logic [$clog2(V_ACTIVE)-1:0] res_y_min,
    output logic [$clog2(V_ACTIVE)-1:0] res_y_max,
    output logic [CW-1:0]               res_count,
    output logic                        res_overrun
);

    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_armed;
    logic          r_dv_d;
    logic          r_vs_d;
    logic [XW-1:0] r_xmin, r_xmax;
    logic [YW-1:0] r_ymin, r_ymax;
    logic [CW-1:0] r_cnt;

    logic w_match;
    logic w_frame_end;
    logic w_line_end;
    logic w_xfer;
    logic w_found;
    logic w_any;

    // Threshold test on the live pixel; thresholds are used as they are now.
    assign w_match     = vid_datavalid
                       && (vid_data[23:16] >= thr_r_min)
                       && (vid_data[15:8]  <= thr_g_max)
                       && (vid_data[7:0]   <= thr_b_max);
    assign w_frame_end = vid_v_sync & ~r_vs_d;
    assign w_line_end  = ~vid_datavalid & r_dv_d;
    assign w_xfer      = res_valid & res_ready;
    assign w_found     = (r_cnt >= CW'(MIN_PIX));
    assign w_any       = (r_cnt != '0);

`ifdef BBOX_OVERLAY_EN
    logic w_on_col;
    logic w_on_row;
    logic w_border;

    // Border of the last reported box, in the current pixel's coordinates.
    assign w_on_col = ((r_x == res_x_min) || (r_x == res_x_max))
                      && (r_y >= res_y_min) && (r_y <= res_y_max);
    assign w_on_row = ((r_y == res_y_min) || (r_y == res_y_max))
                      && (r_x >= res_x_min) && (r_x <= res_x_max);
    assign w_border = res_found && vid_datavalid && (w_on_col || w_on_row);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data      <= '0;
            out_datavalid <= 1'b0;
            out_h_sync    <= 1'b0;
            out_v_sync    <= 1'b0;
            res_valid     <= 1'b0;
            res_found     <= 1'b0;
            res_x_min     <= '0;
            res_x_max     <= '0;
            res_y_min     <= '0;
            res_y_max     <= '0;
            res_count     <= '0;
            res_overrun   <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_armed       <= 1'b0;
            r_dv_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_xmin        <= '1;
            r_xmax        <= '0;
            r_ymin        <= '1;
            r_ymax        <= '0;
            r_cnt         <= '0;
        end else begin
            // Video pass-through, one register stage.
`ifdef BBOX_OVERLAY_EN
            out_data      <= w_border ? 24'hFFFFFF : vid_data;
`else
            out_data      <= vid_data;
`endif
            out_datavalid <= vid_datavalid;
            out_h_sync    <= vid_h_sync;
            out_v_sync    <= vid_v_sync;
            r_dv_d        <= vid_datavalid;
            r_vs_d        <= vid_v_sync;

            // A consumed result drops; a load below takes precedence.
            if (w_xfer) begin
                res_valid <= 1'b0;
            end

            if (w_frame_end) begin
                // Frame end wins over any line end in the same cycle.
                r_x    <= '0;
                r_y    <= '0;
                r_xmin <= '1;
                r_xmax <= '0;
                r_ymin <= '1;
                r_ymax <= '0;
                r_cnt  <= '0;
                if (r_armed) begin
                    res_valid <= 1'b1;
                    res_found <= w_found;
                    res_count <= r_cnt;
                    res_x_min <= w_any ? r_xmin : '0;
                    res_x_max <= w_any ? r_xmax : '0;
                    res_y_min <= w_any ? r_ymin : '0;
                    res_y_max <= w_any ? r_ymax : '0;
                    if (res_valid && !res_ready) begin
                        res_overrun <= 1'b1;
                    end
                end else begin
                    // First (partial) frame after reset is discarded.
                    r_armed <= 1'b1;
                end
            end else begin
                if (vid_datavalid) begin
                    if (r_x != X_LAST) begin
                        r_x <= r_x + XW'(1);
                    end
                end else if (w_line_end) begin
                    r_x <= '0;
                    if (r_y != Y_LAST) begin
                        r_y <= r_y + YW'(1);
                    end
                end

                if (w_match) begin
                    if (r_x < r_xmin) r_xmin <= r_x;
                    if (r_x > r_xmax) r_xmax <= r_x;
                    if (r_y < r_ymin) r_ymin <= r_y;
                    if (r_y > r_ymax) r_ymax <= r_y;
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vid_colour_bbox_tracker.sv
// ---------------------------------------------------------------------------
// tb_vid_colour_bbox_tracker
// Directed frames drive the tracker; expected per-frame results are queued as
// each frame ends and compared when the DUT hands a result over. Video output
// is compared every cycle against the inputs of the previous cycle (with the
// box border drawn when BBOX_OVERLAY_EN is defined).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vid_colour_bbox_tracker;

    typedef struct {
        int found;
        int x0;
        int x1;
        int y0;
        int y1;
        int cnt;
    } res_t;

    logic        clk;
    logic        reset_n;
    logic [23:0] vid_data;
    logic        vid_datavalid;
    logic        vid_h_sync;
    logic        vid_v_sync;
    logic [7:0]  thr_r_min;
    logic [7:0]  thr_g_max;
    logic [7:0]  thr_b_max;
    logic [23:0] out_data;
    logic        out_datavalid;
    logic        out_h_sync;
    logic        out_v_sync;
    logic        res_valid;
    logic        res_ready;
    logic        res_found;
    logic [9:0]  res_x_min;
    logic [9:0]  res_x_max;
    logic [8:0]  res_y_min;
    logic [8:0]  res_y_max;
    logic [19:0] res_count;
    logic        res_overrun;

    vid_colour_bbox_tracker dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vid_data      (vid_data),
        .vid_datavalid (vid_datavalid),
        .vid_h_sync    (vid_h_sync),
        .vid_v_sync    (vid_v_sync),
        .thr_r_min     (thr_r_min),
        .thr_g_max     (thr_g_max),
        .thr_b_max     (thr_b_max),
        .out_data      (out_data),
        .out_datavalid (out_datavalid),
        .out_h_sync    (out_h_sync),
        .out_v_sync    (out_v_sync),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_found     (res_found),
        .res_x_min     (res_x_min),
        .res_x_max     (res_x_max),
        .res_y_min     (res_y_min),
        .res_y_max     (res_y_max),
        .res_count     (res_count),
        .res_overrun   (res_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    bit   b_armed  = 0;
    bit   b_ovr    = 0;
    res_t ov;
    int   cur_x    = 0;
    int   cur_y    = 0;
    bit   vid_chk_en = 0;
    bit   have_prev  = 0;
    logic [26:0] prev_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_match(input logic [23:0] d);
        return (d[23:16] >= thr_r_min) && (d[15:8] <= thr_g_max) && (d[7:0] <= thr_b_max);
    endfunction

    // Non-matching background, some of it just outside the window.
    function automatic logic [23:0] bg_pix();
        case ($urandom_range(0, 2))
            0:       return {8'($urandom), 8'hC0, 8'($urandom)};
            1:       return 24'h4F0000;
            default: return 24'hFF2900;
        endcase
    endfunction

    // Expected {data, dv, hs, vs} one cycle later for the inputs now applied.
    function automatic logic [26:0] vid_expect();
        logic [23:0] d;
        bit          ov_en;
        bit          border;
        d = vid_data;
`ifdef BBOX_OVERLAY_EN
        ov_en = 1;
`else
        ov_en = 0;
`endif
        border = (ov.found != 0)
              && ((((cur_x == ov.x0) || (cur_x == ov.x1)) && cur_y >= ov.y0 && cur_y <= ov.y1)
               || (((cur_y == ov.y0) || (cur_y == ov.y1)) && cur_x >= ov.x0 && cur_x <= ov.x1));
        if (ov_en && vid_datavalid && border) d = 24'hFFFFFF;
        return {d, vid_datavalid, vid_h_sync, vid_v_sync};
    endfunction

    // Per-cycle video check and result scoreboard pop.
    always @(negedge clk) begin
        if (vid_chk_en) begin
            if (have_prev) begin
                chk("video_out", 64'({out_data, out_datavalid, out_h_sync, out_v_sync}), 64'(prev_exp));
            end
            prev_exp  = vid_expect();
            have_prev = 1;
        end
        if (reset_n && res_valid && res_ready) begin
            chk("res_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                res_t e;
                e = exp_q.pop_front();
                chk("res_found", 64'(res_found), 64'(e.found));
                chk("res_count", 64'(res_count), 64'(e.cnt));
                chk("res_x_min", 64'(res_x_min), 64'(e.x0));
                chk("res_x_max", 64'(res_x_max), 64'(e.x1));
                chk("res_y_min", 64'(res_y_min), 64'(e.y0));
                chk("res_y_max", 64'(res_y_max), 64'(e.y1));
            end
        end
    end

    // One frame: a bw x bh block of colour fg at (bx,by); optional stop at
    // (stop_y, stop_x) where vsync replaces the rest of the frame.
    task automatic drive_frame(input int lines, input int ppl, input int bx, input int by,
                               input int bw, input int bh, input logic [23:0] fg,
                               input bit black, input int stop_y, input int stop_x,
                               input bit rdy_pulse);
        int   xmn = 1 << 30, xmx = -1, ymn = 1 << 30, ymx = -1, cnt = 0;
        bit   stopped = 0;
        res_t r;
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < ppl; x++) begin
                if (y == stop_y && x == stop_x) begin
                    stopped = 1;
                    break;
                end
                step();
                cur_x = x;
                cur_y = y;
                vid_datavalid = 1'b1;
                vid_h_sync    = 1'b0;
                vid_v_sync    = 1'b0;
                if (x >= bx && x < bx + bw && y >= by && y < by + bh) vid_data = fg;
                else vid_data = black ? 24'h000000 : bg_pix();
                if (is_match(vid_data)) begin
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                    cnt++;
                end
            end
            if (stopped) break;
            for (int i = 0; i < 4; i++) begin
                step();
                vid_datavalid = 1'b0;
                vid_data      = 24'h000000;
                vid_h_sync    = (i == 1 || i == 2);
            end
        end
        if (!stopped) begin
            repeat (2) step();
        end
        // Frame end: vsync rises.
        step();
        vid_datavalid = 1'b0;
        vid_data      = 24'h000000;
        vid_h_sync    = 1'b0;
        vid_v_sync    = 1'b1;
        if (rdy_pulse) res_ready = 1'b1;
        if (!b_armed) begin
            b_armed = 1;
        end else begin
            r.found = (cnt >= 64) ? 1 : 0;
            r.cnt   = cnt;
            r.x0    = (cnt != 0) ? xmn : 0;
            r.x1    = (cnt != 0) ? xmx : 0;
            r.y0    = (cnt != 0) ? ymn : 0;
            r.y1    = (cnt != 0) ? ymx : 0;
            if (exp_q.size() != 0 && !res_ready) begin
                void'(exp_q.pop_back());
                b_ovr = 1;
            end
            exp_q.push_back(r);
            ov = r;
        end
        step();
        if (rdy_pulse) res_ready = 1'b0;
        step();
        step();
        vid_v_sync = 1'b0;
        repeat (2) step();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) step();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        vid_data      = 24'h0;
        vid_datavalid = 1'b0;
        vid_h_sync    = 1'b0;
        vid_v_sync    = 1'b0;
        thr_r_min     = 8'd80;
        thr_g_max     = 8'd40;
        thr_b_max     = 8'd40;
        res_ready     = 1'b1;
        ov            = '{0, 0, 0, 0, 0, 0};
        repeat (4) step();

        // Reset state.
        chk("rst_res_valid",   64'(res_valid),   64'd0);
        chk("rst_res_found",   64'(res_found),   64'd0);
        chk("rst_res_count",   64'(res_count),   64'd0);
        chk("rst_res_overrun", 64'(res_overrun), 64'd0);
        chk("rst_res_box",     64'({res_x_min, res_x_max, res_y_min, res_y_max}), 64'd0);
        chk("rst_out_video",   64'({out_data, out_datavalid, out_h_sync, out_v_sync}), 64'd0);

        reset_n    = 1'b1;
        vid_chk_en = 1;

        // Frame 0 discarded, frame 1 reports the 10x10 red square.
        drive_frame(64, 112, 100, 50, 10, 10, 24'hFF0000, 0, -1, -1, 0);
        repeat (4) step();
        chk("f0_no_result", 64'(res_valid), 64'd0);
        drive_frame(64, 112, 100, 50, 10, 10, 24'hFF0000, 0, -1, -1, 0);
        wait_drain("f1_drain");

        // Frame 2: same square, border overlaid when the overlay is built in.
        drive_frame(64, 112, 100, 50, 10, 10, 24'hFF0000, 0, -1, -1, 0);
        wait_drain("f2_drain");

        // All-black frame.
        drive_frame(8, 112, 0, 0, 0, 0, 24'h000000, 1, -1, -1, 0);
        wait_drain("black_drain");

        // 5x5 square below MIN_PIX, with G exactly at the threshold.
        drive_frame(12, 32, 20, 3, 5, 5, 24'hC02818, 0, -1, -1, 0);
        wait_drain("small_drain");
        chk("small_overrun", 64'(res_overrun), 64'(b_ovr));

        // Ready pulsed on the frame-end cycle: transfer plus load, no overrun.
        res_ready = 1'b0;
        drive_frame(6, 16, 2, 1, 3, 3, 24'hFF0000, 0, -1, -1, 0);
        repeat (4) step();
        chk("pulse_held_valid", 64'(res_valid), 64'd1);
        drive_frame(6, 16, 4, 2, 2, 2, 24'hFF0000, 0, -1, -1, 1);
        chk("pulse_new_valid", 64'(res_valid), 64'd1);
        chk("pulse_no_overrun", 64'(res_overrun), 64'(b_ovr));
        res_ready = 1'b1;
        wait_drain("pulse_drain");

        // Ready held low over two frame ends: second result wins, overrun set.
        res_ready = 1'b0;
        drive_frame(6, 16, 1, 1, 2, 2, 24'hFF0000, 0, -1, -1, 0);
        drive_frame(12, 16, 3, 1, 9, 9, 24'hFF0000, 0, -1, -1, 0);
        chk("ovr_valid", 64'(res_valid), 64'd1);
        chk("ovr_flag", 64'(res_overrun), 64'(b_ovr));
        res_ready = 1'b1;
        wait_drain("ovr_drain");
        chk("ovr_sticky", 64'(res_overrun), 64'(b_ovr));

        // vsync mid-line 200: column at x=3 covers lines 0..200.
        drive_frame(210, 16, 3, 0, 1, 1000, 24'hFF0000, 0, 200, 8, 0);
        wait_drain("midline_drain");
        // Next frame restarts at x=y=0: single pixel at the origin.
        drive_frame(4, 16, 0, 0, 1, 1, 24'hFF0000, 0, -1, -1, 0);
        wait_drain("origin_drain");

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
